// File: rtl/idct8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct8_pkg                                                     |
// | Description : Shared widths, FSM state type and cosine ROM function for     |
// |               the sequential 8-point inverse DCT.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package idct8_pkg;

  localparam int IDCT_IN_W       = 16;  // coefficient, signed Q8.8
  localparam int IDCT_COS_W      = 16;  // cosine word, signed Q1.14
  localparam int IDCT_OUT_W      = 8;   // output sample, signed integer
  localparam int IDCT_ACC_W      = 35;  // IN_W + COS_W + 3 guard bits for 8 terms
  localparam int IDCT_N_PTS      = 8;
  // Q8.8 * Q1.14 leaves 22 fractional bits in every product.
  localparam int IDCT_FRAC_SHIFT = 22;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_COMP = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Base magnitudes: index 0 carries the C_0 = 1/sqrt(2) factor,
  // indices 1..7 are round(8192 * cos(j*pi/16)).
  function automatic logic [IDCT_COS_W-1:0] cos_base(input logic [2:0] j);
    logic [IDCT_COS_W-1:0] v;
    case (j)
      3'd0:    v = IDCT_COS_W'(5793);
      3'd1:    v = IDCT_COS_W'(8035);
      3'd2:    v = IDCT_COS_W'(7568);
      3'd3:    v = IDCT_COS_W'(6811);
      3'd4:    v = IDCT_COS_W'(5793);
      3'd5:    v = IDCT_COS_W'(4551);
      3'd6:    v = IDCT_COS_W'(3135);
      default: v = IDCT_COS_W'(1598);
    endcase
    return v;
  endfunction

  // ROM[n][k]: fold the phase m = (2n+1)k mod 32 into the first quadrant.
  //   m  0..7  : +base[m]
  //   m  8..15 : -base[16-m]
  //   m 16..23 : -base[m-16]
  //   m 24..31 : +base[32-m]
  // Since 2n+1 is odd and k < 8, m can never be 8, 16 or 24 for k != 0,
  // so index 0 (the C_0-scaled word) is only ever reached with k = 0.
  // The m = 8/24 zero-crossing is still returned as 0 for completeness.
  function automatic logic [IDCT_COS_W-1:0] rom_val(input logic [2:0] n,
                                                     input logic [2:0] k);
    logic [4:0]            odd;
    logic [4:0]            kk;
    logic [4:0]            m;
    logic [2:0]            j;
    logic                  neg;
    logic [IDCT_COS_W-1:0] mag;
    logic [IDCT_COS_W-1:0] res;
    odd = {1'b0, n, 1'b1};
    kk  = {2'b00, k};
    m   = odd * kk;              // 5-bit product is the phase modulo 32
    neg = m[4] ^ m[3];
    // 16-m and 32-m share the same low three bits as -m.
    j   = m[3] ? (3'd0 - m[2:0]) : m[2:0];
    mag = cos_base(j);
    if (m[3] && (m[2:0] == 3'd0)) begin
      res = '0;
    end else if (neg) begin
      res = '0 - mag;
    end else begin
      res = mag;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct8_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct8_mac                                                     |
// | Description : Time-shared multiply-accumulate with round-half-up and        |
// |               saturation to the output sample width.                        |
// | Ports       : clk, clr      - clock, synchronous active-high reset          |
// |               mac_en_i      - accumulate this cycle                         |
// |               first_i       - first term of a sample (load, not add)        |
// |               coef_i        - coefficient, signed Q8.8                      |
// |               cos_i         - cosine word, signed Q1.14                     |
// |               sample_o      - rounded, saturated accumulator value          |
// |               sat_o         - sample_o was clipped                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module idct8_mac
  import idct8_pkg::*;
#(
  parameter int IN_W  = IDCT_IN_W,
  parameter int COS_W = IDCT_COS_W,
  parameter int OUT_W = IDCT_OUT_W,
  parameter int ACC_W = IDCT_ACC_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             mac_en_i,
  input  logic             first_i,
  input  logic [IN_W-1:0]  coef_i,
  input  logic [COS_W-1:0] cos_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             sat_o
);

  localparam int PROD_W = IN_W + COS_W;

  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1 << (IDCT_FRAC_SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-(1 << (OUT_W - 1)));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic                     over_hi;
  logic                     over_lo;

  assign prod     = $signed(coef_i) * $signed(cos_i);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // The first term of each sample overwrites the accumulator, which is
  // what clears it between samples without spending an extra cycle.
  always_comb begin
    acc_d = acc_q;
    if (mac_en_i) begin
      acc_d = first_i ? prod_ext : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Round half up: add half an LSB, then arithmetic shift floors.
  assign biased  = acc_q + ROUND_BIAS;
  assign shifted = biased >>> IDCT_FRAC_SHIFT;
  assign over_hi = (shifted > SAT_MAX);
  assign over_lo = (shifted < SAT_MIN);

  always_comb begin
    sample_o = shifted[OUT_W-1:0];
    sat_o    = 1'b0;
    if (over_hi) begin
      sample_o = {1'b0, {(OUT_W - 1){1'b1}}};
      sat_o    = 1'b1;
    end else if (over_lo) begin
      sample_o = {1'b1, {(OUT_W - 1){1'b0}}};
      sat_o    = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct8_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : idct8_seq                                                     |
// | Description : Sequential 8-point orthonormal inverse DCT. Collects eight    |
// |               Q8.8 coefficients, computes each sample as an 8-term dot      |
// |               product on one shared MAC, then streams eight 8-bit samples.  |
// | Ports       : clk, clr              - clock, synchronous active-high reset  |
// |               in_valid/in_ready     - coefficient handshake                 |
// |               in_data               - X[k], beat order gives k = 0..7       |
// |               out_valid/out_ready   - sample handshake                      |
// |               out_data, out_idx     - sample x[n] and its index n           |
// |               out_sat               - current sample was clipped            |
// |               busy                  - computing or emitting                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module idct8_seq
  import idct8_pkg::*;
#(
  parameter int IN_W  = IDCT_IN_W,
  parameter int COS_W = IDCT_COS_W,
  parameter int OUT_W = IDCT_OUT_W,
  parameter int ACC_W = IDCT_ACC_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_sat,
  output logic             busy
);

  state_t                  state_q;
  state_t                  state_d;
  logic [2:0]              ld_cnt_q;
  logic [2:0]              ld_cnt_d;
  logic [2:0]              n_q;
  logic [2:0]              n_d;
  logic [3:0]              k_q;        // 0..7 MAC terms, 8 = finish cycle
  logic [3:0]              k_d;
  logic [2:0]              oi_q;
  logic [2:0]              oi_d;

  logic [IN_W-1:0]         cbuf_q [IDCT_N_PTS];
  logic [OUT_W-1:0]        sbuf_q [IDCT_N_PTS];
  logic [IDCT_N_PTS-1:0]   satbuf_q;

  logic                    in_fire;
  logic                    out_fire;
  logic                    in_comp;
  logic                    mac_en;
  logic                    mac_first;
  logic                    fin_en;
  logic [IN_W-1:0]         mac_coef;
  logic [COS_W-1:0]        mac_cos;
  logic [OUT_W-1:0]        mac_sample;
  logic                    mac_sat;

  // ---------------------------------------------------------------------------
  // Handshakes. in_ready is masked by clr so nothing is captured in the
  // reset cycle even if the FSM was already sitting in LOAD.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_LOAD) && !clr;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state_q != ST_LOAD);

  assign out_data  = out_valid ? sbuf_q[oi_q] : '0;
  assign out_idx   = out_valid ? oi_q : 3'd0;
  assign out_sat   = out_valid ? satbuf_q[oi_q] : 1'b0;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and counters.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    n_d      = n_q;
    k_d      = k_q;
    oi_d     = oi_q;
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          ld_cnt_d = ld_cnt_q + 3'd1;
          if (ld_cnt_q == 3'd7) begin
            state_d = ST_COMP;
            n_d     = 3'd0;
            k_d     = 4'd0;
          end
        end
      end
      ST_COMP: begin
        if (k_q[3]) begin
          // Finish cycle for sample n_q: move on to the next sample.
          k_d = 4'd0;
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_d = ST_OUT;
            oi_d    = 3'd0;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          oi_d = oi_q + 3'd1;
          if (oi_q == 3'd7) begin
            state_d  = ST_LOAD;
            ld_cnt_d = 3'd0;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_LOAD;
      ld_cnt_q <= 3'd0;
      n_q      <= 3'd0;
      k_q      <= 4'd0;
      oi_q     <= 3'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      n_q      <= n_d;
      k_q      <= k_d;
      oi_q     <= oi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data buffers. They carry no reset: a block is only ever read after it has
  // been completely rewritten, so stale contents after clr are never visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (in_fire) begin
      cbuf_q[ld_cnt_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fin_en) begin
      sbuf_q[n_q]   <= mac_sample;
      satbuf_q[n_q] <= mac_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // MAC datapath: one coefficient and one ROM word per cycle.
  // ---------------------------------------------------------------------------
  assign in_comp   = (state_q == ST_COMP);
  assign mac_en    = in_comp && !k_q[3];
  assign mac_first = (k_q == 4'd0);
  assign fin_en    = in_comp && k_q[3] && !clr;
  assign mac_coef  = cbuf_q[k_q[2:0]];
  assign mac_cos   = rom_val(n_q, k_q[2:0]);

  idct8_mac #(
    .IN_W  (IN_W),
    .COS_W (COS_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .clr      (clr),
    .mac_en_i (mac_en),
    .first_i  (mac_first),
    .coef_i   (mac_coef),
    .cos_i    (mac_cos),
    .sample_o (mac_sample),
    .sat_o    (mac_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_idct8_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_idct8_seq                                                  |
// | Description : Self-checking bench for idct8_seq with a real-arithmetic      |
// |               IDCT model and a per-cycle compare process.                   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_idct8_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_sat;
  logic        busy;

  idct8_seq dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: cosine table from real arithmetic, exact integer MAC,
  // round half up, clip to 8 bits.
  // ---------------------------------------------------------------------------
  function automatic int rom_ref(input int n, input int k);
    real c;
    real v;
    c = (k == 0) ? (1.0 / $sqrt(2.0)) : 1.0;
    v = 16384.0 * (c / 2.0) * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  int exp_val [8];
  bit exp_sat [8];

  function automatic void compute_expected(input int x [8]);
    for (int n = 0; n < 8; n++) begin
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'(x[k]) * longint'(rom_ref(n, k));
      r = (acc + 64'sd2097152) >>> 22;
      exp_sat[n] = 1'b0;
      if (r > 127)       begin r = 127;  exp_sat[n] = 1'b1; end
      else if (r < -128) begin r = -128; exp_sat[n] = 1'b1; end
      exp_val[n] = int'(r);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: tracks the block through collect / compute / emit and
  // checks every DUT output on every negative edge.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int ph = 0;            // 0 collecting, 1 computing, 2 emitting
  int cnt = 0;
  int oi = 0;
  int t_done = 0;
  int blocks_done = 0;
  int stall_cnt = 0;
  bit after_rst = 1'b0;
  int xin [8];

  always @(negedge clk) begin
    if (clr) begin
      check("in_ready_during_clr", in_ready, 0);
      ph = 0; cnt = 0; oi = 0;
      after_rst = 1'b1;
    end else begin
      if (ph == 1 && cyc == t_done + 73) ph = 2;
      case (ph)
        0: begin
          check("load_in_ready", in_ready, 1);
          check("load_out_valid", out_valid, 0);
          check("load_busy", busy, 0);
          if (after_rst) begin
            check("rst_out_data", $signed(out_data), 0);
            check("rst_out_idx", out_idx, 0);
            check("rst_out_sat", out_sat, 0);
          end
        end
        1: begin
          check("comp_in_ready", in_ready, 0);
          check("comp_out_valid", out_valid, 0);
          check("comp_busy", busy, 1);
        end
        default: begin
          check("out_out_valid", out_valid, 1);
          check("out_in_ready", in_ready, 0);
          check("out_busy", busy, 1);
          check("out_idx", out_idx, oi);
          check("out_data", $signed(out_data), exp_val[oi]);
          check("out_sat", out_sat, exp_sat[oi]);
        end
      endcase
      after_rst = 1'b0;
      if (ph == 0 && in_valid) begin
        xin[cnt] = int'($signed(in_data));
        cnt++;
        if (cnt == 8) begin
          compute_expected(xin);
          ph = 1;
          t_done = cyc;
          cnt = 0;
        end
      end else if (ph == 2) begin
        if (!out_ready && oi == 3) stall_cnt++;
        if (out_ready) begin
          oi++;
          if (oi == 8) begin
            ph = 0;
            oi = 0;
            blocks_done++;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sink: 0 always ready, 1 random, 2 stall five cycles at index 3.
  // ---------------------------------------------------------------------------
  int or_mode = 0;
  bit bp_done = 1'b0;

  always begin
    @(posedge clk);
    #1;
    case (or_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (out_valid && out_idx == 3'd3 && !bp_done) begin
          out_ready = 1'b0;
          repeat (5) @(posedge clk);
          #1;
          out_ready = 1'b1;
          bp_done = 1'b1;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Source
  // ---------------------------------------------------------------------------
  logic [15:0] blk [8];

  // gap_mode: 0 back-to-back, 1 one idle cycle before each beat, 2 random.
  task automatic send_block(input int gap_mode);
    for (int k = 0; k < 8; k++) begin
      int  w;
      bit  hs;
      int  gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
      if (gaps > 0) begin
        in_valid = 1'b0;
        repeat (gaps) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = blk[k];
      w  = 0;
      hs = 1'b0;
      while (!hs && w < 3000) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!hs) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no in_ready, expected beat %0d accepted", k);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_blocks(input int target);
    int w;
    w = 0;
    while (blocks_done < target && w < 3000) begin
      @(posedge clk);
      w++;
    end
    check("blocks_completed", blocks_done, target);
  endtask

  task automatic fill_random(input bit full_range);
    for (int k = 0; k < 8; k++) begin
      if (full_range) blk[k] = 16'($urandom_range(0, 65535));
      else            blk[k] = 16'($urandom_range(0, 8000)) - 16'd4000;
    end
  endtask

  task automatic fill_dc();
    for (int k = 0; k < 8; k++) blk[k] = 16'd0;
    blk[0] = 16'd7240;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int pin_x [8];
  int ac_exp [8] = '{49, 42, 28, 10, -10, -28, -42, -49};
  int nblk;

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;

    // Hand-computed anchors for the model itself.
    pin_x = '{7240, 0, 0, 0, 0, 0, 0, 0};
    compute_expected(pin_x);
    for (int n = 0; n < 8; n++) begin
      check("pin_dc_val", exp_val[n], 10);
      check("pin_dc_sat", exp_sat[n], 0);
    end
    pin_x = '{0, 25600, 0, 0, 0, 0, 0, 0};
    compute_expected(pin_x);
    for (int n = 0; n < 8; n++) check("pin_ac_val", exp_val[n], ac_exp[n]);
    pin_x = '{32767, 32767, 32767, 32767, 0, 0, 0, 0};
    compute_expected(pin_x);
    check("pin_sat_x0", exp_val[0], 127);
    check("pin_sat_s0", exp_sat[0], 1);
    check("pin_sat_x7", exp_val[7], -12);
    check("pin_sat_s7", exp_sat[7], 0);

    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    nblk = 0;

    // DC block
    or_mode = 0;
    fill_dc();
    send_block(0);
    nblk++; wait_blocks(nblk);

    // Single AC term, random gaps, random sink
    or_mode = 1;
    for (int k = 0; k < 8; k++) blk[k] = 16'd0;
    blk[1] = 16'd25600;
    send_block(2);
    nblk++; wait_blocks(nblk);

    // Saturation with a five-cycle stall at index 3
    or_mode = 2; bp_done = 1'b0; stall_cnt = 0;
    for (int k = 0; k < 8; k++) blk[k] = (k < 4) ? 16'h7FFF : 16'h0000;
    send_block(0);
    nblk++; wait_blocks(nblk);
    check("backpressure_stall_cycles", stall_cnt, 5);

    // Reset in the middle of COMP, then a fresh DC block
    or_mode = 0;
    fill_dc();
    blk[3] = 16'd1234;
    send_block(0);
    repeat (30) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("blocks_after_abort", blocks_done, nblk);
    fill_dc();
    send_block(0);
    nblk++; wait_blocks(nblk);

    // Back-to-back blocks with toggling in_valid
    or_mode = 1;
    fill_random(1'b0);
    send_block(1);
    fill_random(1'b0);
    send_block(1);
    nblk += 2; wait_blocks(nblk);

    // Random blocks, mixed ranges
    for (int b = 0; b < 6; b++) begin
      fill_random(b[0]);
      send_block(2);
      nblk++; wait_blocks(nblk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idct8_seq.md
Name: idct8_seq

Overview:
- Sequential 8-point 1D inverse DCT (orthonormal, DCT-II inverse).
- Converts the eight scaled coefficients produced by the team's DCT pipeline back into 8-bit signed samples.
- Coefficients stream in over a valid/ready handshake. One time-shared MAC computes each sample as an 8-term dot product against a cosine ROM. Samples stream out over a valid/ready handshake.
- Sits between the coefficient source (switch loader or DCT core) and the seven-segment/LED display path of the board top.

Parameters:
- IN_W, 16, coefficient width, signed Q8.8
- COS_W, 16, cosine ROM width, signed Q1.14
- OUT_W, 8, output sample width, signed integer
- ACC_W, 35, accumulator width (IN_W+COS_W+3)
- Only the defaults are verified; other values are unsupported.

Ports:
- clk  in  1  system clock (100 MHz)
- clr  in  1  synchronous active-high reset
- in_valid  in  1  coefficient beat valid
- in_ready  out  1  block can accept a coefficient
- in_data  in  16  coefficient X[k], signed Q8.8; k implied by beat order 0..7
- out_valid  out  1  sample beat valid
- out_ready  in  1  sink accepts sample
- out_data  out  8  sample x[n], signed integer
- out_idx  out  3  n of the current out_data
- out_sat  out  1  current sample was clipped
- busy  out  1  high in COMP or OUT

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous and active-high; it is sampled on posedge clk.
- Reset values: in_ready=0 during the reset cycle; out_valid=0, out_data=0, out_idx=0, out_sat=0, busy=0. The FSM enters LOAD with load count=0, and in_ready=1 from the next cycle.
- Reset mid-operation: any state is abandoned, and buffered coefficients and samples are discarded. clr has priority over every other event.
- FSM states: LOAD, COMP, OUT.
- LOAD:
  - in_ready=1.
  - A beat transfers when in_valid&in_ready; it is written to cbuf[k] and k increments.
  - Gaps in in_valid are allowed.
  - On the 8th transfer, go to COMP next cycle; in_ready=0 from that cycle.
- COMP:
  - For n=0..7: 8 MAC cycles (k=0..7, acc += cbuf[k]*ROM[n][k]), then 1 finish cycle. The finish cycle rounds, saturates and writes sbuf[n] and satbuf[n].
  - The accumulator clears at the start of each n.
  - COMP lasts 72 cycles. out_valid rises exactly 73 cycles after the cycle of the 8th input transfer.
- Arithmetic:
  - Each product is a full 32-bit signed value, Q?.22. The accumulator is ACC_W-bit signed, with no overflow possible.
  - Rounding: r = (acc + 2^21) >>> 22, an arithmetic shift (round half up).
  - Saturation: r>127 gives 127, r<-128 gives -128, and the sat flag is set.
- ROM: ROM[n][k] = round(2^14 * (C_k/2) * cos((2n+1)k*pi/16)), with C_0=1/sqrt(2) and C_k=1 otherwise.
  - Base magnitudes for k=0..7: 5793, 8035, 7568, 6811, 5793, 4551, 3135, 1598.
- OUT:
  - out_valid=1, with out_data=sbuf[i], out_idx=i, out_sat=satbuf[i].
  - On out_valid&out_ready, i increments. All outputs hold stable while out_ready=0.
  - After the transfer with i=7: out_valid=0 next cycle, FSM returns to LOAD, in_ready=1 that same next cycle.
- Simultaneous events: in LOAD, in_valid is ignored while clr=1. In OUT, a new input cannot be accepted (in_ready=0), so there is no input/output overlap.

Decomposition:
- Package idct8_pkg:
  - width localparams
  - the 8 base cosine magnitudes
  - the function rom_val(n,k), which derives sign and index from (2n+1)k mod 32
  - FSM state enum
- One natural sub-module: idct8_mac. It takes cbuf data and the ROM word, accumulates, and performs round and saturate. The FSM, buffers and handshakes stay in idct8_seq.

Test Plan:
- DC: X0=7240 (28.28), X1..X7=0 -> all eight out_data=10, out_sat=0, out_idx 0..7 in order; out_valid exactly 73 cycles after the last input transfer.
- Single AC: X1=25600 (100.0), others 0 -> out_data = 49, 42, 28, 10, -10, -28, -42, -49.
- Saturation: X0..X3=16'h7FFF, X4..X7=0 -> x[0]=127 with out_sat=1; x[7]=-12 with out_sat=0.
- Backpressure: hold out_ready=0 for 5 cycles when out_idx=3 -> out_data/out_idx/out_sat stable, in_ready=0 throughout; the sequence resumes with idx 4 and no sample is lost or duplicated.
- Reset mid-COMP: assert clr for 1 cycle at COMP cycle 30 -> next cycle all outputs at reset values, in_ready=1 the cycle after. A fresh DC block then yields all 10.
- Back-to-back with gaps: two blocks, in_valid toggling 1/0 -> second block is accepted only after the first block's 8th output; both results are correct.
